regs_dump: RTL and testbench
============================

Name: regs_dump

Overview:
- Read-side client of the register memory. On request, walks every register address through the memory's read port and streams each word out over a valid/ready interface.
- Sits beside the register file in the debug path. It shares the read port with the datapath through an external mux selected by busy; the host is the UART/LED debug sink.
- Accounts for the memory's one-cycle registered read latency and supports back-pressure.

Parameters:
- WIDTH, 8, register word width in bits; matches the register size.
- DEPTH, 32, number of registers walked.
- AW, $clog2(DEPTH), address width in bits.

Ports:
- clk  input  1  system clock. One clock; reset is asynchronous and active-high.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- reg_rd_addr  output  AW  drives the register memory read address.
- reg_q  input  WIDTH  registered memory read data; valid one clock after reg_rd_addr is sampled.
- busy  output  1  high in every state except IDLE; selects this block onto the read port.
- dump_data  output  WIDTH  word being presented.
- dump_addr  output  AW  register index of dump_data.
- dump_valid  output  1  dump_data/dump_addr are valid.
- dump_ready  input  1  sink accepts the word when dump_valid && dump_ready at a rising edge.
- dump_last  output  1  qualifies the final word of a dump.
- done  output  1  single-cycle pulse after the final word is accepted.

Behaviour:
- Reset (asynchronous, takes effect immediately, any state): state=IDLE; reg_rd_addr=0, dump_data=0, dump_addr=0, dump_valid=0, dump_last=0, busy=0, done=0, internal address counter=0. Reset mid-dump abandons the dump with no done pulse.
- FSM states: IDLE, ISSUE, CAPTURE, PRESENT, FINISH.
- IDLE:
  - start=1 -> counter=0, reg_rd_addr=0, go to ISSUE.
  - start=0 -> stay in IDLE.
- ISSUE: memory samples reg_rd_addr at this edge -> go to CAPTURE.
- CAPTURE: reg_q now holds mem[counter].
  - Latch dump_data=reg_q and dump_addr=counter.
  - Set dump_valid=1; set dump_last=1 if counter==DEPTH-1.
  - Go to PRESENT.
- PRESENT:
  - Hold dump_data, dump_addr, dump_valid and dump_last stable until the handshake.
  - On dump_valid && dump_ready: clear dump_valid. If counter==DEPTH-1, go to FINISH. Otherwise increment counter, drive reg_rd_addr=counter+1, and go to ISSUE.
- FINISH: done=1 for exactly one cycle -> IDLE.
- Throughput: 3 clocks per word with dump_ready tied high. First dump_valid appears 3 edges after start is sampled.
- reg_rd_addr changes only on the IDLE->ISSUE and PRESENT->ISSUE transitions.
- start while busy is ignored; no queuing.
- Writes to the register memory during a dump are legal. Each word reflects the memory content at the edge its address was sampled. The memory read is not write-through, so a same-cycle write to the address being read returns the old value.
- Counter wrap: never increments past DEPTH-1.

Optional Feature:
- Macro REGS_DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of every accepted data word is kept; it is cleared on start.
  - After register DEPTH-1 is accepted, the FSM enters state SUM instead of FINISH and presents one extra word: dump_data=XOR, dump_addr=0, dump_valid=1, dump_last=1.
  - dump_last is therefore 0 on register DEPTH-1.
  - After SUM is accepted -> FINISH.
- Undefined: no SUM state, no accumulator; dump_last is on register DEPTH-1.

Decomposition:
- Shared package holds WIDTH/DEPTH/AW defaults (aligned with the register-size constants) and the state enum typedef.
- No sub-module is needed. The output holding register with handshake is small enough to stay inline.

Test Plan:
- Power-up dump, all registers at unity 0x10, ready tied high: pulse start -> 32 words, addr 0..31, each data 0x10. First valid 3 cycles after start, 3-cycle spacing. dump_last only on addr 31, then a single done pulse. Checksum on: dump_last moves to the extra word, data 0x00.
- Back-pressure: preload reg n = n+1, hold dump_ready low 5 cycles on addr 2 -> dump_data=0x03 stable throughout, reg_rd_addr stays 2, no word lost or duplicated.
- Same-cycle write: write 0xAA to reg 4 on the edge its address is sampled -> dump shows the old 0x10. Write 0xAA to reg 5 while addr 4 is presented -> addr 5 shows 0xAA.
- Start ignored when busy: pulse start again mid-dump -> sequence unaffected, exactly 32 (33 with checksum) words, one done pulse.
- Async reset at addr 10 in PRESENT -> all outputs 0 immediately, no done pulse. A new start dumps from addr 0.
- Checksum on, regs = 0x01,0x02,0x04,0x08,0x10, rest 0x00 -> final word 0x1F with dump_last=1, dump_addr=0.

Source files
------------

// File: rtl/regs_dump_pkg.sv
// Shared constants and FSM state type for the register dump client.
// Default sizes follow the register file word width and register count.
package regs_dump_pkg;

   localparam int REG_WIDTH = 8;
   localparam int REG_DEPTH = 32;
   localparam int REG_AW    = $clog2(REG_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_PRESENT = 3'd3,
      ST_SUM     = 3'd4,
      ST_FINISH  = 3'd5
   } state_e;

endpackage

// File: rtl/regs_dump_if.sv
// Bundle of the dump client's control, memory read port and output stream.
// master = regs_dump side, slave = memory/host side.
interface regs_dump_if
   import regs_dump_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH,
   parameter int AW    = REG_AW
);
   logic             start;
   logic             busy;
   logic             done;
   logic [AW-1:0]    reg_rd_addr;
   logic [WIDTH-1:0] reg_q;
   logic [WIDTH-1:0] dump_data;
   logic [AW-1:0]    dump_addr;
   logic             dump_valid;
   logic             dump_ready;
   logic             dump_last;

   modport master (
      input  start, reg_q, dump_ready,
      output busy, done, reg_rd_addr, dump_data, dump_addr, dump_valid, dump_last
   );

   modport slave (
      output start, reg_q, dump_ready,
      input  busy, done, reg_rd_addr, dump_data, dump_addr, dump_valid, dump_last
   );
endinterface

// File: rtl/regs_dump.sv
// Walks every register through the shared read port and streams the words out
// over valid/ready. Optional trailing XOR word: define REGS_DUMP_CHECKSUM_EN.
module regs_dump
   import regs_dump_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH,
   parameter int DEPTH = REG_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   regs_dump_if.master bus
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_e           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    rd_addr_q, rd_addr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             busy_q;
   logic             done_q;
`ifdef REGS_DUMP_CHECKSUM_EN
   logic [WIDTH-1:0] sum_q, sum_d;
`endif

   // State and output holding registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rd_addr_q <= '0;
         data_q    <= '0;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef REGS_DUMP_CHECKSUM_EN
         sum_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_addr_q <= rd_addr_d;
         data_q    <= data_d;
         addr_q    <= addr_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_d == ST_FINISH);
`ifdef REGS_DUMP_CHECKSUM_EN
         sum_q     <= sum_d;
`endif
      end
   end

   // Next-state and datapath decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_addr_d = rd_addr_q;
      data_d    = data_q;
      addr_d    = addr_q;
      valid_d   = valid_q;
      last_d    = last_q;
`ifdef REGS_DUMP_CHECKSUM_EN
      sum_d     = sum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               cnt_d     = '0;
               rd_addr_d = '0;
`ifdef REGS_DUMP_CHECKSUM_EN
               sum_d     = '0;
`endif
               state_d   = ST_ISSUE;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // reg_q is one cycle behind the address issued in ISSUE
            data_d  = bus.reg_q;
            addr_d  = cnt_q;
            valid_d = 1'b1;
`ifdef REGS_DUMP_CHECKSUM_EN
            last_d  = 1'b0;
`else
            last_d  = (cnt_q == LAST_IDX);
`endif
            state_d = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (valid_q && bus.dump_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
`ifdef REGS_DUMP_CHECKSUM_EN
               sum_d   = sum_q ^ data_q;
`endif
               if (cnt_q == LAST_IDX) begin
`ifdef REGS_DUMP_CHECKSUM_EN
                  data_d  = sum_q ^ data_q;
                  addr_d  = '0;
                  valid_d = 1'b1;
                  last_d  = 1'b1;
                  state_d = ST_SUM;
`else
                  state_d = ST_FINISH;
`endif
               end else begin
                  cnt_d     = cnt_q + AW'(1);
                  rd_addr_d = cnt_q + AW'(1);
                  state_d   = ST_ISSUE;
               end
            end else begin
               state_d = ST_PRESENT;
            end
         end
         ST_SUM: begin
            if (valid_q && bus.dump_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = ST_FINISH;
            end else begin
               state_d = ST_SUM;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.reg_rd_addr = rd_addr_q;
   assign bus.dump_data   = data_q;
   assign bus.dump_addr   = addr_q;
   assign bus.dump_valid  = valid_q;
   assign bus.dump_last   = last_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_regs_dump.sv
// Directed bench for regs_dump: behavioural register memory with registered,
// non-write-through read, stream logger, and hand-computed expectations.
module tb_regs_dump;
   import regs_dump_pkg::*;

`ifdef REGS_DUMP_CHECKSUM_EN
   localparam int NW = 33;
`else
   localparam int NW = 32;
`endif

   logic clk;
   logic reset;
   regs_dump_if #(.WIDTH(8), .AW(5)) bus ();

   regs_dump #(.WIDTH(8), .DEPTH(32), .AW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] mem [32];
   logic       we;
   logic [4:0] wa;
   logic [7:0] wd;
   logic [7:0] exp_mem [32];

   logic [7:0] got_data [$];
   logic [4:0] got_addr [$];
   logic       got_last [$];
   int         got_cyc  [$];
   int         cyc;
   int         done_cnt;
   int         n_cmp;
   int         n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // register memory: write port plus registered read returning the old value
   always @(posedge clk) begin
      if (we) mem[wa] <= wd;
      bus.reg_q <= mem[bus.reg_rd_addr];
   end

   // log every word offered while ready is high (accepted at the next edge)
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!reset && bus.dump_valid && bus.dump_ready) begin
         got_data.push_back(bus.dump_data);
         got_addr.push_back(bus.dump_addr);
         got_last.push_back(bus.dump_last);
         got_cyc.push_back(cyc);
      end
      if (bus.done) done_cnt <= done_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [7:0] d);
      we = 1'b1; wa = a; wd = d;
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   // mode 0: all 0x10, mode 1: n+1, mode 2: one-hot low five, rest 0
   task automatic load_mem(input int mode);
      for (int i = 0; i < 32; i++) begin
         logic [7:0] v;
         if (mode == 0)      v = 8'h10;
         else if (mode == 1) v = 8'(i + 1);
         else                v = (i < 5) ? (8'h01 << i) : 8'h00;
         exp_mem[i] = v;
         write_reg(5'(i), v);
      end
   endtask

   task automatic pulse_start(output int base);
      base = got_data.size();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // mode 0: present word at address a, mode 1: read address equals a
   task automatic wait_for(input string tag, input int mode, input logic [4:0] a);
      bit ok = 1'b0;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(posedge clk); #1;
         if (mode == 0) ok = bus.dump_valid && (bus.dump_addr == a);
         else           ok = (bus.reg_rd_addr == a);
      end
      check_eq(tag, 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input string tag, input int base_done);
      int n = 0;
      while (done_cnt == base_done && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_done"}, done_cnt, base_done + 1);
      repeat (6) @(posedge clk);
      #1;
      check_eq({tag, "_one_done"}, done_cnt, base_done + 1);
      check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic verify(input string tag, input int base, input bit spacing);
      logic [7:0] s = 8'h00;
      check_eq({tag, "_count"}, got_data.size() - base, NW);
      if (got_data.size() - base == NW) begin
         for (int i = 0; i < 32; i++) begin
            bit el;
`ifdef REGS_DUMP_CHECKSUM_EN
            el = 1'b0;
`else
            el = (i == 31);
`endif
            check_eq($sformatf("%s_addr%0d", tag, i), 32'(got_addr[base+i]), 32'(i));
            check_eq($sformatf("%s_data%0d", tag, i), 32'(got_data[base+i]), 32'(exp_mem[i]));
            check_eq($sformatf("%s_last%0d", tag, i), 32'(got_last[base+i]), 32'(el));
            if (spacing && i > 0)
               check_eq($sformatf("%s_gap%0d", tag, i), got_cyc[base+i] - got_cyc[base+i-1], 32'd3);
            s ^= exp_mem[i];
         end
`ifdef REGS_DUMP_CHECKSUM_EN
         check_eq({tag, "_sum_data"}, 32'(got_data[base+32]), 32'(s));
         check_eq({tag, "_sum_addr"}, 32'(got_addr[base+32]), 32'd0);
         check_eq({tag, "_sum_last"}, 32'(got_last[base+32]), 32'd1);
`endif
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_valid"}, 32'(bus.dump_valid), 32'd0);
      check_eq({tag, "_data"},  32'(bus.dump_data),  32'd0);
      check_eq({tag, "_addr"},  32'(bus.dump_addr),  32'd0);
      check_eq({tag, "_rdaddr"}, 32'(bus.reg_rd_addr), 32'd0);
      check_eq({tag, "_last"},  32'(bus.dump_last),  32'd0);
      check_eq({tag, "_busy"},  32'(bus.busy),       32'd0);
      check_eq({tag, "_done"},  32'(bus.done),       32'd0);
   endtask

   initial begin
      int base;
      int bd;
      n_cmp = 0; n_err = 0; cyc = 0; done_cnt = 0;
      reset = 1'b1; bus.start = 1'b0; bus.dump_ready = 1'b1;
      we = 1'b0; wa = 5'd0; wd = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("rst");
      reset = 1'b0;

      // power-up dump, ready tied high
      load_mem(0);
      bd = done_cnt;
      pulse_start(base);
      check_eq("t1_busy", 32'(bus.busy), 32'd1);
      check_eq("t1_v0", 32'(bus.dump_valid), 32'd0);
      @(posedge clk); #1;
      check_eq("t1_v1", 32'(bus.dump_valid), 32'd0);
      @(posedge clk); #1;
      check_eq("t1_v2", 32'(bus.dump_valid), 32'd1);
      check_eq("t1_first_addr", 32'(bus.dump_addr), 32'd0);
      check_eq("t1_first_data", 32'(bus.dump_data), 32'h10);
      wait_done("t1", bd);
      verify("t1", base, 1'b1);

      // back-pressure on address 2
      load_mem(1);
      bd = done_cnt;
      pulse_start(base);
      wait_for("t2_poll", 0, 5'd2);
      bus.dump_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check_eq($sformatf("t2_hold_data%0d", k), 32'(bus.dump_data), 32'h03);
         check_eq($sformatf("t2_hold_addr%0d", k), 32'(bus.dump_addr), 32'd2);
         check_eq($sformatf("t2_hold_valid%0d", k), 32'(bus.dump_valid), 32'd1);
         check_eq($sformatf("t2_hold_rd%0d", k), 32'(bus.reg_rd_addr), 32'd2);
      end
      bus.dump_ready = 1'b1;
      wait_done("t2", bd);
      verify("t2", base, 1'b0);

      // same-cycle writes, plus a start pulse while busy
      load_mem(0);
      bd = done_cnt;
      pulse_start(base);
      wait_for("t3_poll_rd4", 1, 5'd4);
      write_reg(5'd4, 8'hAA);
      wait_for("t3_poll_p4", 0, 5'd4);
      write_reg(5'd5, 8'hAA);
      exp_mem[5] = 8'hAA;
      wait_for("t3_poll_p10", 0, 5'd10);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done("t3", bd);
      verify("t3", base, 1'b1);

      // async reset while presenting address 10
      load_mem(1);
      bd = done_cnt;
      pulse_start(base);
      wait_for("t5_poll", 0, 5'd10);
      check_eq("t5_pre_data", 32'(bus.dump_data), 32'h0B);
      reset = 1'b1;
      #1;
      check_zero_outputs("t5_rst");
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_eq("t5_no_done", done_cnt, bd);
      check_eq("t5_no_busy", 32'(bus.busy), 32'd0);
      pulse_start(base);
      wait_done("t5b", bd);
      verify("t5b", base, 1'b1);

      // checksum pattern
      load_mem(2);
      bd = done_cnt;
      pulse_start(base);
      wait_done("t6", bd);
      verify("t6", base, 1'b1);
      if (got_data.size() - base == NW) begin
`ifdef REGS_DUMP_CHECKSUM_EN
         check_eq("t6_final_1f", 32'(got_data[base+32]), 32'h1F);
         check_eq("t6_final_last", 32'(got_last[base+32]), 32'd1);
`else
         check_eq("t6_final_data", 32'(got_data[base+31]), 32'h00);
         check_eq("t6_final_last", 32'(got_last[base+31]), 32'd1);
`endif
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
